// File: rtl/r200_fwd_ctrl.sv
// r200_fwd_ctrl: forwarding and hazard controller for the r200 pipeline.
// A small scoreboard follows every in-flight destination write through the
// post-ID stages (slot 0 = EX ... slot FWD_STAGES-1 = WB). From it the block
// derives the ID operand forwarding selects, load-use and multi-cycle stalls,
// the ID flush on redirect, and a saturating count of front-end stall cycles.
module r200_fwd_ctrl #(
    parameter int FWD_STAGES = 3,
    parameter int RADDR_W    = 5,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(FWD_STAGES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_id_valid,
    input  logic [RADDR_W-1:0] i_id_rs1,
    input  logic [RADDR_W-1:0] i_id_rs2,
    input  logic               i_id_rs1_used,
    input  logic               i_id_rs2_used,
    input  logic [RADDR_W-1:0] i_id_rd,
    input  logic               i_id_regwr,
    input  logic               i_id_isload,
    input  logic               i_id_mc,
    input  logic               i_ex_mc_done,
    input  logic               i_redirect,
    output logic [SEL_W-1:0]   o_rs1_fwdsel,
    output logic [SEL_W-1:0]   o_rs2_fwdsel,
    output logic               o_stall_fe,
    output logic               o_bubble_ex,
    output logic               o_flush_id,
    output logic [CNT_W-1:0]   o_stall_cnt
);

    // Scoreboard slot fields. The multi-cycle attribute is only relevant
    // while the op sits in EX, so it is held in r_mc_busy rather than being
    // carried down the slots.
    logic [FWD_STAGES-1:0] r_valid;
    logic [FWD_STAGES-1:0] r_regwr;
    logic [FWD_STAGES-1:0] r_isload;
    logic [RADDR_W-1:0]    r_rd [FWD_STAGES];
    logic                  r_mc_busy;
    logic [CNT_W-1:0]      r_stall_cnt;

    logic [FWD_STAGES-1:0] w_match1;
    logic [FWD_STAGES-1:0] w_match2;
    logic [SEL_W-1:0]      w_sel1;
    logic [SEL_W-1:0]      w_sel2;
    logic                  w_lu1;
    logic                  w_lu2;
    logic                  w_lu_stall;
    logic                  w_mc_stall;
    logic                  w_stall_fe;
    logic                  w_bubble_ex;
    logic                  w_issue;

    // Per-slot match against each ID source; x0 and unread operands never match.
    generate
        for (genvar gi = 0; gi < FWD_STAGES; gi++) begin : g_match
            assign w_match1[gi] = r_valid[gi] & r_regwr[gi] & (r_rd[gi] == i_id_rs1)
                                & (i_id_rs1 != '0) & i_id_rs1_used;
            assign w_match2[gi] = r_valid[gi] & r_regwr[gi] & (r_rd[gi] == i_id_rs2)
                                & (i_id_rs2 != '0) & i_id_rs2_used;
        end
    endgenerate

    // Youngest-match priority select for rs1: scan oldest to youngest so the
    // lowest matching slot is the one left standing.
    always_comb begin
        w_sel1 = '0;
        w_lu1  = 1'b0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (w_match1[k]) begin
                w_sel1 = SEL_W'(k + 1);
                w_lu1  = r_isload[k] & (k < LOAD_LAT);
            end
        end
    end

    // Youngest-match priority select for rs2, same scheme as rs1.
    always_comb begin
        w_sel2 = '0;
        w_lu2  = 1'b0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (w_match2[k]) begin
                w_sel2 = SEL_W'(k + 1);
                w_lu2  = r_isload[k] & (k < LOAD_LAT);
            end
        end
    end

    // Hazard combine. A redirect flushes ID, so it must not also hold the
    // front end for a load-use on the instruction being killed.
    assign w_lu_stall  = w_lu1 | w_lu2;
    assign w_mc_stall  = r_mc_busy & ~i_ex_mc_done;
    assign w_stall_fe  = i_id_valid & ((w_lu_stall & ~i_redirect) | w_mc_stall);
    assign w_bubble_ex = w_lu_stall | i_redirect;
    assign w_issue     = i_id_valid & ~w_bubble_ex;

    assign o_rs1_fwdsel = w_sel1;
    assign o_rs2_fwdsel = w_sel2;
    assign o_stall_fe   = w_stall_fe;
    assign o_bubble_ex  = w_bubble_ex;
    assign o_flush_id   = i_redirect;
    assign o_stall_cnt  = r_stall_cnt;

    // Scoreboard advance. While a multi-cycle op occupies EX, slot 0 holds it,
    // slot 1 receives a bubble and the older slots keep draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= '0;
            r_regwr  <= '0;
            r_isload <= '0;
            for (int k = 0; k < FWD_STAGES; k++) begin
                r_rd[k] <= '0;
            end
        end else begin
            for (int k = 1; k < FWD_STAGES; k++) begin
                if (w_mc_stall && k == 1) begin
                    r_valid[k] <= 1'b0;
                end else begin
                    r_valid[k] <= r_valid[k-1];
                end
                r_regwr[k]  <= r_regwr[k-1];
                r_isload[k] <= r_isload[k-1];
                r_rd[k]     <= r_rd[k-1];
            end
            if (!w_mc_stall) begin
                r_valid[0]  <= w_issue;
                r_regwr[0]  <= i_id_regwr;
                r_isload[0] <= i_id_isload;
                r_rd[0]     <= i_id_rd;
            end
        end
    end

    // Multi-cycle busy flag: raised when an mc op enters EX, dropped on done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mc_busy <= 1'b0;
        end else if (w_issue && i_id_mc && !w_mc_stall) begin
            r_mc_busy <= 1'b1;
        end else if (i_ex_mc_done) begin
            r_mc_busy <= 1'b0;
        end
    end

    // Saturating count of cycles the front end was held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall_fe && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_r200_fwd_ctrl.sv
// Directed bench for r200_fwd_ctrl: a default instance plus a CNT_W=4
// instance on the same stimulus for the counter saturation case.
module tb_r200_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, rs1_used, rs2_used, regwr, isload, mc, mc_done, redirect;
    logic [4:0] rs1, rs2, rd;

    logic [1:0]  sel1_a, sel2_a, sel1_b, sel2_b;
    logic        stall_a, bub_a, flush_a, stall_b, bub_b, flush_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    r200_fwd_ctrl u_dut (
        .clk(clk), .rst(rst), .i_id_valid(id_valid), .i_id_rs1(rs1), .i_id_rs2(rs2),
        .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used), .i_id_rd(rd),
        .i_id_regwr(regwr), .i_id_isload(isload), .i_id_mc(mc),
        .i_ex_mc_done(mc_done), .i_redirect(redirect),
        .o_rs1_fwdsel(sel1_a), .o_rs2_fwdsel(sel2_a), .o_stall_fe(stall_a),
        .o_bubble_ex(bub_a), .o_flush_id(flush_a), .o_stall_cnt(cnt_a)
    );

    r200_fwd_ctrl #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .i_id_valid(id_valid), .i_id_rs1(rs1), .i_id_rs2(rs2),
        .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used), .i_id_rd(rd),
        .i_id_regwr(regwr), .i_id_isload(isload), .i_id_mc(mc),
        .i_ex_mc_done(mc_done), .i_redirect(redirect),
        .o_rs1_fwdsel(sel1_b), .o_rs2_fwdsel(sel2_b), .o_stall_fe(stall_b),
        .o_bubble_ex(bub_b), .o_flush_id(flush_b), .o_stall_cnt(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [4:0] a1, input logic u1,
                       input logic [4:0] a2, input logic u2, input logic [4:0] d,
                       input logic w, input logic ld, input logic m);
        id_valid = v; rs1 = a1; rs1_used = u1; rs2 = a2; rs2_used = u2;
        rd = d; regwr = w; isload = ld; mc = m;
    endtask

    // Inputs change 1 time unit after the edge; checks at edge+4.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; mc_done = 1'b0; redirect = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_sel1", sel1_a, 0);
        chk("rst_stall", stall_a, 0);
        chk("rst_bubble", bub_a, 0);
        chk("rst_flush", flush_a, 0);
        chk("rst_cnt", cnt_a, 0);
        chk("rst_cnt4", cnt_b, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Back-to-back ALU: add x5, then a reader of x5 ageing through slots.
        drv(1, 0, 0, 0, 0, 5, 1, 0, 0); #3;
        chk("alu_issue_stall", stall_a, 0);
        nxt();
        drv(1, 5, 1, 0, 0, 0, 0, 0, 0); #3;
        chk("alu_fwd_slot0", sel1_a, 1);
        chk("alu_nostall", stall_a, 0);
        nxt(); #3;
        chk("alu_fwd_slot1", sel1_a, 2);
        nxt(); #3;
        chk("alu_fwd_slot2", sel1_a, 3);
        nxt(); #3;
        chk("alu_fwd_gone", sel1_a, 0);
        nxt();

        // Load-use: lw x7 then add reading rs2=x7.
        drv(1, 0, 0, 0, 0, 7, 1, 1, 0); #3;
        chk("lw_issue_stall", stall_a, 0);
        nxt();
        drv(1, 0, 0, 7, 1, 8, 1, 0, 0); #3;
        chk("lu_stall", stall_a, 1);
        chk("lu_bubble", bub_a, 1);
        chk("lu_flush", flush_a, 0);
        chk("lu_sel2", sel2_a, 1);
        chk("lu_cnt_before", cnt_a, 0);
        nxt(); #3;
        chk("lu_released", stall_a, 0);
        chk("lu_nobubble", bub_a, 0);
        chk("lu_sel2_after", sel2_a, 2);
        chk("lu_cnt_after", cnt_a, 1);
        nxt();

        // Youngest wins: two writers of x3 back to back.
        drv(1, 0, 0, 0, 0, 3, 1, 0, 0); nxt();
        drv(1, 0, 0, 0, 0, 3, 1, 0, 0); nxt();
        drv(1, 3, 1, 3, 1, 0, 0, 0, 0); #3;
        chk("young_sel1", sel1_a, 1);
        chk("young_sel2", sel2_a, 1);
        rs1_used = 1'b0; #1;
        chk("unused_sel1", sel1_a, 0);
        chk("unused_keep_sel2", sel2_a, 1);
        nxt();

        // x0 is never forwarded, even right behind a write to x0.
        drv(1, 0, 0, 0, 0, 0, 1, 0, 0); nxt();
        drv(1, 0, 1, 0, 1, 11, 1, 0, 0); #3;
        chk("x0_sel1", sel1_a, 0);
        chk("x0_sel2", sel2_a, 0);
        nxt();

        // Multi-cycle op writing x9; done arrives on the fifth cycle in EX.
        drv(1, 0, 0, 0, 0, 9, 1, 0, 1); #3;
        chk("mc_issue_stall", stall_a, 0);
        nxt();
        drv(1, 9, 1, 11, 1, 10, 1, 0, 0); #3;
        chk("mc_stall_c1", stall_a, 1);
        chk("mc_nobubble", bub_a, 0);
        chk("mc_sel1_c1", sel1_a, 1);
        chk("mc_sel2_c1", sel2_a, 2);
        nxt(); #3;
        chk("mc_stall_c2", stall_a, 1);
        chk("mc_sel2_c2", sel2_a, 3);
        nxt(); #3;
        chk("mc_stall_c3", stall_a, 1);
        chk("mc_slot1_empty", sel2_a, 0);
        nxt(); #3;
        chk("mc_stall_c4", stall_a, 1);
        nxt();
        mc_done = 1'b1;
        drv(1, 9, 1, 0, 0, 10, 1, 0, 0); #3;
        chk("mc_done_nostall", stall_a, 0);
        chk("mc_done_sel1", sel1_a, 1);
        chk("mc_cnt", cnt_a, 5);
        nxt();
        mc_done = 1'b0;
        drv(1, 10, 1, 0, 0, 0, 0, 0, 0); #3;
        chk("mc_after_stall", stall_a, 0);
        chk("mc_dep_sel1", sel1_a, 1);
        chk("mc_cnt_hold", cnt_a, 5);
        nxt();

        // Redirect in the same cycle as a load-use.
        drv(1, 0, 0, 0, 0, 12, 1, 1, 0); nxt();
        redirect = 1'b1;
        drv(1, 12, 1, 0, 0, 12, 1, 0, 0); #3;
        chk("redir_flush", flush_a, 1);
        chk("redir_nostall", stall_a, 0);
        chk("redir_bubble", bub_a, 1);
        nxt();
        redirect = 1'b0; #3;
        chk("redir_slot0_empty", sel1_a, 2);
        chk("redir_noflush", flush_a, 0);
        chk("redir_cnt", cnt_a, 5);
        nxt();

        // Saturation: 20 mc stall cycles; the 4-bit counter pins at 15.
        drv(1, 0, 0, 0, 0, 13, 1, 0, 1); nxt();
        drv(1, 13, 1, 0, 0, 14, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            nxt();
        end
        #3;
        chk("sat_stall", stall_a, 1);
        chk("sat_stall4", stall_b, 1);
        chk("sat_cnt16", cnt_a, 25);
        chk("sat_cnt4", cnt_b, 15);

        // Asynchronous reset in the middle of the mc stall.
        #1 rst = 1'b1;
        #1;
        chk("arst_stall", stall_a, 0);
        chk("arst_cnt", cnt_a, 0);
        chk("arst_cnt4", cnt_b, 0);
        chk("arst_sel1", sel1_a, 0);
        nxt();
        rst = 1'b0; #3;
        chk("post_rst_stall", stall_a, 0);
        chk("post_rst_sel1", sel1_a, 0);
        nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/r200_fwd_ctrl.md
Name: r200_fwd_ctrl

Overview:
- Parametrised forwarding and hazard controller for the r200 pipeline family; successor to the fixed 3-source hazard unit.
- Keeps its own scoreboard of in-flight destination writes, one slot per post-ID stage, FWD_STAGES deep.
- Drives per-operand forwarding selects for the ID operand muxes, load-use and multi-cycle stalls, and ID flush on redirect.
- Keeps a saturating stall-cycle counter.

Parameters:
- FWD_STAGES, 3: post-ID stages tracked; slot 0 = EX, slot FWD_STAGES-1 = WB.
- RADDR_W, 5: register address width.
- LOAD_LAT, 1: slots a load occupies before its data is forwardable; a load in slot k < LOAD_LAT is not forwardable.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  RADDR_W  ID source registers
- id_rs1_used, id_rs2_used  in  1  operand actually read
- id_rd  in  RADDR_W  ID destination
- id_regwr  in  1  ID instruction writes rd
- id_isload  in  1  ID instruction is a load
- id_mc  in  1  ID instruction is multi-cycle in EX
- ex_mc_done  in  1  multi-cycle EX op completes this cycle
- redirect  in  1  taken branch/jump resolved in EX this cycle
- rs1_fwdsel, rs2_fwdsel  out  $clog2(FWD_STAGES+1)  0 = regfile, k+1 = slot k result
- stall_fe  out  1  hold PC and IF/ID register
- bubble_ex  out  1  insert bubble into ID/EX
- flush_id  out  1  kill instruction in IF/ID
- stall_cnt  out  CNT_W  stall cycles since reset, saturating

Behaviour:
- Slot state: valid, rd, regwr, isload, mc.
- Reset (async, rst=1): all slot valid=0, stall_cnt=0, internal mc_busy=0. Outputs settle to fwdsel=0, stall_fe=0, bubble_ex=0, flush_id=0. Reset mid-stall or mid-mc-op clears everything at once.
- Match rule: slot k matches rsX when valid & regwr & rd==rsX & rsX!=0 & rsX_used.
- Forwarding is combinational. fwdsel = k+1 for the smallest (youngest) matching k; 0 if no slot matches; always 0 for x0.
- Load-use: the youngest match is a load with k < LOAD_LAT -> lu_stall=1. Its fwdsel is still driven but ignored.
- mc_busy: set on the edge where an id_mc instruction enters slot 0; cleared on the edge where ex_mc_done=1.
- mc_stall = mc_busy & !ex_mc_done.
- stall_fe = id_valid & (lu_stall | mc_stall).
- bubble_ex = lu_stall | redirect.
- flush_id = redirect. redirect overrides lu_stall for stall_fe: flush wins, no stall.
- Slot update on each clk edge when not mc_stall:
  - slot[k] <= slot[k-1] for k >= 1.
  - slot0 <= ID instruction if id_valid & !bubble_ex, else invalid.
- During mc_stall: slot0 holds; slot1 <= invalid; slots 2.. shift.
- stall_cnt increments by 1 on each edge where stall_fe=1; holds at all-ones.
- Simultaneous ex_mc_done and redirect: mc completes, ID flushed, slot0 <= invalid.
- Latency: selects and stalls are valid in the same cycle as the ID inputs. Scoreboard reflects a newly issued instruction one edge later.

Test Plan:
- Back-to-back ALU: issue add x5 (regwr), next ID reads rs1=x5 -> rs1_fwdsel=1, no stall. One cycle later with a bubble between -> fwdsel=2. Two bubbles -> fwdsel=3. Three bubbles -> fwdsel=0.
- Load-use, LOAD_LAT=1: lw x7 followed by add rs2=x7 -> stall_fe=1, bubble_ex=1 for exactly 1 cycle. Next cycle rs2_fwdsel=2, stall_cnt=1.
- Youngest wins and x0: slot0 and slot1 both write x3, ID reads x3 -> fwdsel=1. Any write to x0 with ID reading x0 -> fwdsel=0. rs1_used=0 -> fwdsel=0.
- Multi-cycle: id_mc op issued, ex_mc_done asserted 4 cycles after entry -> stall_fe=1 for 4 cycles, slot1 empty during stall. stall_cnt +4. Dependent instruction then gets fwdsel=1.
- Redirect during load-use: redirect=1 in the same cycle as lu_stall -> flush_id=1, stall_fe=0, bubble_ex=1. Next cycle slot0 invalid and stall_cnt unchanged.
- Reset and saturation: CNT_W=4 with 20 stall cycles -> stall_cnt=15. Assert rst mid-mc-stall -> stall_fe=0 and stall_cnt=0 immediately, before the next clk.
